// File: rtl/lenet_pkg.sv
// Shared LeNet-5 pipeline types and helpers.
// Activation width, FSM states and flatten addressing.
package lenet_pkg;

  localparam int datatype_size = 4;

  typedef logic [datatype_size-1:0] act_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    LAUNCH = 2'd2
  } flat_state_t;

  // Channel-major flatten: each channel owns a
  // contiguous block of img_width^2 pixels.
  function automatic int unsigned flat_addr(
    input int unsigned ch,
    input int unsigned pix,
    input int unsigned img_width
  );
    return ch * img_width * img_width + pix;
  endfunction

endpackage

// File: rtl/pool_fc_flatten.sv
// Pool-to-FC adapter: serialises channel vectors
// into the FC input buffer, then launches the FC.
module pool_fc_flatten
  import lenet_pkg::*;
#(
  parameter int input_channels = 16,
  parameter int img_width      = 4,
  localparam int input_size    =
    input_channels * img_width * img_width,
  localparam int aw = $clog2(input_size),
  localparam int cw = $clog2(input_channels),
  localparam int pw = $clog2(img_width * img_width)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic [input_channels-1:0]
               [datatype_size-1:0]   i_data,
  output logic                       o_busy,
  input  logic                       i_fc_busy,
  output logic                       o_ibuf_we,
  output act_t                       o_ibuf_wr_data,
  output logic [aw-1:0]              o_ibuf_addr,
  output logic                       o_start
);

  flat_state_t state_q, state_d;

  logic [cw-1:0] ch_q;
  logic [pw-1:0] pix_q;
  logic [input_channels-1:0]
        [datatype_size-1:0] cap_q;

  logic accept;
  logic last_ch;
  logic last_pix;
  logic do_write;
  logic do_launch;

  assign last_ch  = ch_q == cw'(input_channels - 1);
  assign last_pix = pix_q == pw'(img_width * img_width - 1);

  // Handshake and per-state qualifiers.
  always_comb begin
    o_busy    = (state_q != IDLE) | i_fc_busy;
    accept    = i_valid & ~o_busy;
    do_write  = (state_q == WRITE) & ~i_fc_busy;
    do_launch = (state_q == LAUNCH) & ~i_fc_busy;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) state_d = WRITE;
      WRITE:
        if (do_write && last_ch)
          state_d = last_pix ? LAUNCH : IDLE;
      LAUNCH:
        if (do_launch) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Capture, counters and registered ibuf/start outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q          <= '0;
      ch_q           <= '0;
      pix_q          <= '0;
      o_ibuf_we      <= 1'b0;
      o_ibuf_wr_data <= '0;
      o_ibuf_addr    <= '0;
      o_start        <= 1'b0;
    end else begin
      o_ibuf_we <= 1'b0;
      o_start   <= 1'b0;
      if (accept) begin
        cap_q <= i_data;
        ch_q  <= '0;
      end
      if (do_write) begin
        o_ibuf_we      <= 1'b1;
        o_ibuf_wr_data <= cap_q[ch_q];
        o_ibuf_addr    <= aw'(flat_addr(
          32'(ch_q), 32'(pix_q), img_width));
        if (last_ch) begin
          ch_q <= '0;
          if (!last_pix) pix_q <= pix_q + 1'b1;
        end else begin
          ch_q <= ch_q + 1'b1;
        end
      end
      if (do_launch) begin
        o_start <= 1'b1;
        pix_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pool_fc_flatten.sv
// Scoreboard bench for pool_fc_flatten.
// Expected ibuf writes are queued on accept.
module tb_pool_fc_flatten;
  import lenet_pkg::*;

  typedef logic [15:0][3:0] vec_t;
  typedef struct {
    logic [7:0] addr;
    logic [3:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  vec_t       i_data;
  logic       o_busy;
  logic       i_fc_busy;
  logic       o_ibuf_we;
  act_t       o_ibuf_wr_data;
  logic [7:0] o_ibuf_addr;
  logic       o_start;

  pool_fc_flatten dut (
    .clk            (clk),
    .rst            (rst),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_busy         (o_busy),
    .i_fc_busy      (i_fc_busy),
    .o_ibuf_we      (o_ibuf_we),
    .o_ibuf_wr_data (o_ibuf_wr_data),
    .o_ibuf_addr    (o_ibuf_addr),
    .o_start        (o_start)
  );

  always #5 clk = ~clk;

  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;
  int  last_we_cyc = 0;
  int  mpix   = 0;
  int  starts_pending = 0;
  int  frame_wr = 0;
  bit  launch_blocked = 0;
  bit  seen [256];
  wr_t exp_q [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h t=%0t",
                  tag, got, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pop expected writes, track frame end.
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      if (o_ibuf_we) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", o_ibuf_addr, e.addr);
          check("wr_data", o_ibuf_wr_data, e.data);
        end
        check("addr_once", seen[o_ibuf_addr], 0);
        seen[o_ibuf_addr] = 1'b1;
        frame_wr++;
        last_we_cyc = cyc;
      end
      if (o_start) begin
        check("start_expected", starts_pending > 0, 1);
        check("frame_writes", frame_wr, 256);
        check("start_q_empty", exp_q.size(), 0);
        if (!launch_blocked)
          check("start_gap", cyc - last_we_cyc, 1);
        if (starts_pending > 0) starts_pending--;
        frame_wr = 0;
        foreach (seen[i]) seen[i] = 1'b0;
      end
    end
  end

  task automatic push_vec(input vec_t v);
    for (int k = 0; k < 16; k++)
      exp_q.push_back('{addr: 8'(flat_addr(k, mpix, 4)),
                        data: v[k]});
    mpix++;
    if (mpix == 16) begin
      mpix = 0;
      starts_pending++;
    end
  endtask

  // Called and returns just after a falling edge.
  task automatic send_vec(input vec_t v, input bit hold);
    int n = 0;
    while (o_busy && n < 400) begin
      i_valid = hold;
      if (hold) i_data = vec_t'({$urandom, $urandom});
      @(negedge clk);
      n++;
    end
    if (o_busy) begin
      check("accept_timeout", 1, 0);
      return;
    end
    i_valid = 1'b1;
    i_data  = v;
    @(posedge clk);
    push_vec(v);
    @(negedge clk);
    i_valid = hold;
    if (hold) i_data = vec_t'({$urandom, $urandom});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || starts_pending != 0)
           && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", exp_q.size() + starts_pending, 0);
    @(negedge clk);
  endtask

  function automatic vec_t pat(input int p);
    vec_t v;
    for (int k = 0; k < 16; k++) v[k] = 4'((p + k) & 15);
    return v;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    mpix = 0;
    starts_pending = 0;
    frame_wr = 0;
    foreach (seen[i]) seen[i] = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    i_valid = 1'b0;
    i_fc_busy = 1'b0;
    i_data = '0;
    repeat (2) @(negedge clk);
    check("rst_we", o_ibuf_we, 0);
    check("rst_data", o_ibuf_wr_data, 0);
    check("rst_addr", o_ibuf_addr, 0);
    check("rst_start", o_start, 0);
    check("rst_busy", o_busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single vector: channel k carries k.
    send_vec(pat(0), 0);
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("single_busy_cycles", n, 16);
    drain();

    // Four more vectors, reset in the middle of the fifth.
    for (int p = 1; p < 5; p++) begin
      send_vec(pat(p), 0);
      if (p < 4) drain();
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_we", o_ibuf_we, 0);
    check("mid_rst_data", o_ibuf_wr_data, 0);
    check("mid_rst_addr", o_ibuf_addr, 0);
    check("mid_rst_start", o_start, 0);
    check("mid_rst_busy", o_busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // Full frame, no stalls, back to back.
    for (int p = 0; p < 16; p++) send_vec(pat(p), 0);
    drain();

    // Stall during channel 7 of pixel 2.
    for (int p = 0; p < 16; p++) begin
      send_vec(pat(p + 3), 0);
      if (p == 2) begin
        repeat (7) @(negedge clk);
        i_fc_busy = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("stall_we", o_ibuf_we, 0);
        end
        i_fc_busy = 1'b0;
      end
    end
    drain();

    // i_valid held high with junk data while busy.
    for (int p = 0; p < 16; p++)
      send_vec(pat(p + 7), p != 15);
    drain();

    // Launch blocked by the FC layer.
    for (int p = 0; p < 15; p++) send_vec(pat(p + 9), 0);
    drain();
    send_vec(pat(5), 0);
    repeat (16) @(negedge clk);
    i_fc_busy = 1'b1;
    launch_blocked = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("blocked_start", o_start, 0);
      check("blocked_busy", o_busy, 1);
    end
    i_fc_busy = 1'b0;
    @(negedge clk);
    check("launch_start", o_start, 1);
    @(negedge clk);
    launch_blocked = 1'b0;
    check("launch_single", o_start, 0);
    check("launch_pending", starts_pending, 0);
    send_vec(pat(11), 0);
    drain();
    check("post_launch_pix", mpix, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
